header_encoder: RTL

Streaming instruction-header encoder: accepts abstract operation requests (operation, immediate flag, branch condition) over a valid/ready handshake and emits the 10-bit instruction headers that the control unit decodes. Encoded headers are buffered in a small FIFO toward the instruction-fetch/loader path. The block serves as the hardware assembler back end for the self-test sequencer and the program loader. Illegal requests become NOP headers and raise an error pulse.

---
 rtl/isa_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 46 ++++
 rtl/header_encoder.sv | 95 +++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Instruction-set constants shared by the header encoder and the control unit:
// operation codes, header class codes and per-class opcodes.
package isa_pkg;

    localparam int HDR_W = 10;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_SUB = 4'd1,
        OP_ADD = 4'd2,
        OP_MOV = 4'd3,
        OP_CMP = 4'd4,
        OP_AVR = 4'd5,
        OP_CUM = 4'd6,
        OP_STR = 4'd7,
        OP_LPX = 4'd8,
        OP_SPX = 4'd9,
        OP_LDR = 4'd10,
        OP_BR  = 4'd11
    } op_t;

    localparam logic [1:0] CLS_DATA = 2'b00;
    localparam logic [1:0] CLS_MEM  = 2'b01;
    localparam logic [1:0] CLS_BR   = 2'b10;
    localparam logic [1:0] CLS_NOP  = 2'b11;

    localparam logic [3:0] DOP_SUB = 4'b0001;
    localparam logic [3:0] DOP_ADD = 4'b0010;
    localparam logic [3:0] DOP_MOV = 4'b0011;
    localparam logic [3:0] DOP_CMP = 4'b0111;
    localparam logic [3:0] DOP_AVR = 4'b1010;
    localparam logic [3:0] DOP_CUM = 4'b1011;

    localparam logic [1:0] MOP_STR = 2'b00;
    localparam logic [1:0] MOP_LPX = 2'b01;
    localparam logic [1:0] MOP_SPX = 2'b10;
    localparam logic [1:0] MOP_LDR = 2'b11;

    localparam logic [HDR_W-1:0] HDR_NOP = {3'b000, CLS_NOP, 5'b00000};

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is presented combinationally
// and reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/header_encoder.sv
// Encodes operation requests into 10-bit instruction headers and queues them
// for the fetch/loader path; illegal requests become NOP headers plus an err pulse.
module header_encoder
    import isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_imm,
    input  logic [2:0]       in_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [HDR_W-1:0] out_header,
    output logic             err,
    output logic [15:0]      hdr_count
);

    function automatic logic is_illegal(logic [3:0] op, logic imm);
        logic bad;
        bad = 1'b0;
        if (op > OP_BR) begin
            bad = 1'b1;
        end else if ((op == OP_AVR || op == OP_CUM) && imm) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [HDR_W-1:0] encode(logic [3:0] op, logic imm, logic [2:0] cond);
        logic [HDR_W-1:0] h;
        h = HDR_NOP;
        case (op)
            OP_SUB:  h = {3'b000, CLS_DATA, imm, DOP_SUB};
            OP_ADD:  h = {3'b000, CLS_DATA, imm, DOP_ADD};
            OP_MOV:  h = {3'b000, CLS_DATA, imm, DOP_MOV};
            OP_CMP:  h = {3'b000, CLS_DATA, imm, DOP_CMP};
            OP_AVR:  h = {3'b000, CLS_DATA, 1'b0, DOP_AVR};
            OP_CUM:  h = {3'b000, CLS_DATA, 1'b0, DOP_CUM};
            OP_STR:  h = {3'b000, CLS_MEM, MOP_STR, 3'b000};
            OP_LPX:  h = {3'b000, CLS_MEM, MOP_LPX, 3'b000};
            OP_SPX:  h = {3'b000, CLS_MEM, MOP_SPX, 3'b000};
            OP_LDR:  h = {3'b000, CLS_MEM, MOP_LDR, 3'b000};
            OP_BR:   h = {cond, CLS_BR, 5'b00000};
            default: h = HDR_NOP;
        endcase
        return h;
    endfunction

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             illegal;
    logic [HDR_W-1:0] enc_header;

    assign illegal    = is_illegal(in_op, in_imm);
    assign enc_header = illegal ? HDR_NOP : encode(in_op, in_imm, in_cond);

    // A full FIFO refuses requests even when a pop frees a slot on the same edge.
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .WIDTH(HDR_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(enc_header),
        .pop  (pop),
        .rdata(out_header),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err       <= 1'b0;
            hdr_count <= '0;
        end else begin
            err <= push && illegal;
            if (pop) begin
                hdr_count <= hdr_count + 16'd1;
            end
        end
    end

endmodule
